accum_arbiter: RTL
==================

ACCUM_ARBITER -- requirements
Module: accum_arbiter

Interface
REQ-001 SHALL have parameter OP_W, default 3, operand width per requester.
REQ-002 SHALL have parameter ACC_W, default 4, accumulator width (OP_W+1).
REQ-003 SHALL have port Clock  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  2  request, bit i from requester i.
REQ-006 SHALL have port a0  input  OP_W  operand of requester 0.
REQ-007 SHALL have port a1  input  OP_W  operand of requester 1.
REQ-008 SHALL have port clr  input  1  synchronous accumulator clear request.
REQ-009 SHALL have port grant  output  2  one-hot grant, 1-cycle pulse.
REQ-010 SHALL have port acc  output  ACC_W  accumulator value, registered.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port done  output  1  1-cycle pulse when an addition has committed.
REQ-013 SHALL have port ovf  output  1  sticky carry-out/overflow flag.

Function
REQ-014 SHALL implement FSM states IDLE, GRANT, EXEC, DONE; one state per cycle outside IDLE.
REQ-015 IDLE: if req!=0 and clr=0, SHALL select a winner and go to GRANT; else stay.
REQ-016 Arbitration SHALL be round-robin: single request wins; both requesting -> requester other than last winner.
REQ-017 Last-winner pointer SHALL update only on entry to GRANT.
REQ-018 GRANT: grant[winner]=1 for exactly this cycle; winner operand latched into internal op register; next EXEC.
REQ-019 EXEC: acc <= low ACC_W bits of acc + zero-extended op; ovf set if carry out of ACC_W bits; next DONE.
REQ-020 DONE: done=1 for this cycle; next IDLE; total latency req-sampled to done = 3 cycles.
REQ-021 Requests arriving or dropping while busy SHALL be ignored until IDLE; a request dropped after GRANT still completes.
REQ-022 clr SHALL be honoured only in IDLE: acc <= 0, ovf <= 0, no grant that cycle even if req!=0.
REQ-023 clr outside IDLE SHALL be ignored (no effect on acc, ovf, or state).
REQ-024 Without saturation, acc SHALL wrap modulo 2^ACC_W (e.g. 14+3 -> 1, ovf=1).
REQ-025 grant and done SHALL never be high in the same cycle; grant SHALL be 0 outside GRANT.

Reset
REQ-026 Reset low SHALL immediately force state IDLE, acc=0, ovf=0, grant=0, done=0, busy=0, op=0.
REQ-027 Reset SHALL set last-winner pointer to requester 1, so requester 0 wins the first tie.
REQ-028 Reset asserted mid-operation SHALL abort it; no done pulse and no acc update on release.

Configuration
REQ-029 Macro ACC_SAT_EN defined: EXEC SHALL clamp acc at 2^ACC_W-1 on carry, still setting ovf.
REQ-030 Macro ACC_SAT_EN undefined: EXEC SHALL wrap per REQ-024; no saturation logic present.

Verification
REQ-031 Reset low then high; req=01, a0=5 -> grant=01 at cycle 1, done at cycle 3, acc=5, ovf=0.
REQ-032 req=11 held, a0=2, a1=3 from reset -> grants alternate 01,10,01,10; acc=2,5,7,10 after each done.
REQ-033 acc=14, req=10, a1=3 -> acc=1, ovf=1 (ACC_SAT_EN off); acc=15, ovf=1 (ACC_SAT_EN on).
REQ-034 clr=1 with req=01 in IDLE, acc=9 -> acc=0, ovf=0, grant=00 that cycle; grant=01 next cycle if req held.
REQ-035 Reset low during EXEC with acc=4, op=3 -> acc=0, state IDLE, no done pulse after release.
REQ-036 req=01 dropped after GRANT, clr=1 pulsed in EXEC -> addition completes, done pulses, acc updated, clr ignored.

Source files
------------

// File: rtl/accum_arbiter.sv
// accum_arbiter: two-requester round-robin arbiter feeding a registered accumulator.
// Define ACC_SAT_EN to clamp the accumulator at all-ones on carry instead of wrapping.
module accum_arbiter #(
  parameter int OP_W  = 3,
  parameter int ACC_W = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [1:0]       req,
  input  logic [OP_W-1:0]  a0,
  input  logic [OP_W-1:0]  a1,
  input  logic             clr,
  output logic [1:0]       grant,
  output logic [ACC_W-1:0] acc,
  output logic             busy,
  output logic             done,
  output logic             ovf
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  logic [1:0]       state_q, state_d;
  logic             last_q, last_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum;
  logic             start, win, clr_idle;
  always_comb begin
    clr_idle = state_q == IDLE && clr;
    start    = state_q == IDLE && |req && !clr;
    // on a tie the requester that did not win last time goes next
    win      = req == 2'b11 ? ~last_q : req[1];
    sum      = {1'b0, acc_q} + {{(ACC_W+1-OP_W){1'b0}}, op_q};
    state_d  = state_q == IDLE ? (start ? GRANT : IDLE) :
               state_q == DONE ? IDLE : state_q + 2'd1;
    last_d   = start ? win : last_q;
    op_d     = state_q == GRANT ? (last_q ? a1 : a0) : op_q;
`ifdef ACC_SAT_EN
    acc_d    = clr_idle ? '0 : state_q == EXEC ? (sum[ACC_W] ? '1 : sum[ACC_W-1:0]) : acc_q;
`else
    acc_d    = clr_idle ? '0 : state_q == EXEC ? sum[ACC_W-1:0] : acc_q;
`endif
    ovf_d    = clr_idle ? 1'b0 : state_q == EXEC ? (ovf_q | sum[ACC_W]) : ovf_q;
  end
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      op_q    <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end
  assign grant = state_q == GRANT ? (last_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy  = state_q != IDLE;
  assign done  = state_q == DONE;
  assign acc   = acc_q;
  assign ovf   = ovf_q;
endmodule
